// File: rtl/apb_manager_if.sv
// Command, response and APB bus signals of apb_manager bundled into one interface.
// The master modport is the manager's view; slave is the view of whatever surrounds it.
interface apb_manager_if #(
  parameter int AWIDTH = 10,
  parameter int DBYTES = 4,
  parameter int DWIDTH = DBYTES * 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [2:0]        cmd_prot;
  logic [DBYTES-1:0] cmd_strb;
  logic [DWIDTH-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [2:0]        pprot;
  logic [AWIDTH-1:0] paddr;
  logic [DBYTES-1:0] pstrb;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_prot, cmd_strb, cmd_wdata,
    input  rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, pprot, paddr, pstrb, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_prot, cmd_strb, cmd_wdata,
    output rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, pprot, paddr, pstrb, pwdata
  );
endinterface

// File: rtl/apb_manager.sv
// Single-outstanding APB requester: turns one command into a SETUP/ACCESS transfer
// and holds the result in RESP until the response is consumed.
module apb_manager #(
  parameter int         AWIDTH  = 10,
  parameter logic [2:0] DSIZE   = 3'd2,
  parameter int         DBYTES  = 1 << DSIZE,
  parameter int         DWIDTH  = DBYTES * 8,
  parameter int         TIMEOUT = 16
) (
  input logic           pclk,
  input logic           presetn,
  apb_manager_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam int             CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [2:0]        pprot_q, pprot_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DBYTES-1:0] pstrb_q, pstrb_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CW-1:0]     wait_q, wait_d;

  // The wait counter only advances on stalled ACCESS cycles; pready wins over a timeout
  // firing in the same cycle because it is tested first.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pprot_d   = pprot_q;
    paddr_d   = paddr_q;
    pstrb_d   = pstrb_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = S_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          pprot_d   = bus.cmd_prot;
          paddr_d   = bus.cmd_addr;
          pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
          pwdata_d  = bus.cmd_wdata;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      S_ACCESS: begin
        if (bus.pready) begin
          state_d   = S_RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = bus.pslverr;
          rdata_d   = pwrite_q ? '0 : bus.prdata;
        end else if (TIMEOUT > 0) begin
          if (wait_q == WAIT_LAST) begin
            state_d   = S_RESP;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            err_d     = 1'b1;
            rdata_d   = '0;
          end else begin
            wait_d = wait_q + CW'(1);
          end
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pprot_q   <= '0;
      paddr_q   <= '0;
      pstrb_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pprot_q   <= pprot_d;
      paddr_q   <= paddr_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pprot     = pprot_q;
  assign bus.paddr     = paddr_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: doc/apb_manager.md
APB_MANAGER -- requirements
Module: apb_manager

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, address width in bits.
REQ-002 SHALL have parameter DSIZE [2:0], default 2, data size (2^DSIZE bytes).
REQ-003 SHALL have parameter DBYTES, default 1<<DSIZE, data bytes (derived, not overridden).
REQ-004 SHALL have parameter DWIDTH, default DBYTES*8, data width in bits (derived).
REQ-005 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles without pready; 0 disables timeout.
REQ-006 SHALL have ports:
  pclk  in  1  clock, rising edge
  presetn  in  1  asynchronous active-low reset
  cmd_valid  in  1  command request
  cmd_ready  out  1  command accepted when high with cmd_valid
  cmd_write  in  1  1=write, 0=read
  cmd_addr  in  AWIDTH  target address
  cmd_prot  in  3  protection attribute
  cmd_strb  in  DBYTES  write byte strobes
  cmd_wdata  in  DWIDTH  write data
  rsp_valid  out  1  response available
  rsp_ready  in  1  response consumed when high with rsp_valid
  rsp_rdata  out  DWIDTH  read data
  rsp_err  out  1  slave error or timeout
  psel / penable / pwrite  out  1  APB control
  pprot  out  3;  paddr  out  AWIDTH;  pstrb  out  DBYTES;  pwdata  out  DWIDTH
  prdata  in  DWIDTH;  pready  in  1;  pslverr  in  1

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at most.
REQ-008 cmd_ready SHALL be high only in IDLE; rsp_valid SHALL be high only in RESP.
REQ-009 IDLE & cmd_valid: SHALL register addr, prot, write, strb, wdata and go to SETUP next cycle.
REQ-010 SETUP: psel=1, penable=0; SHALL always go to ACCESS next cycle.
REQ-011 ACCESS: psel=1, penable=1; paddr, pprot, pwrite, pstrb, pwdata SHALL be stable from SETUP through final ACCESS cycle.
REQ-012 ACCESS & pready: SHALL capture rsp_err=pslverr, rsp_rdata=prdata on reads and 0 on writes; go to RESP; psel and penable SHALL be 0 the following cycle.
REQ-013 pstrb SHALL be driven to 0 for read transfers.
REQ-014 TIMEOUT>0: wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; on the TIMEOUT-th such cycle SHALL go to RESP with rsp_err=1, rsp_rdata=0, psel=penable=0 next cycle.
REQ-015 pready sampled high in the same cycle that the timeout would fire SHALL take precedence (normal completion).
REQ-016 TIMEOUT=0: SHALL wait in ACCESS indefinitely.
REQ-017 RESP & rsp_ready: SHALL go to IDLE next cycle; rsp_rdata/rsp_err SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-018 Latency: cmd handshake in cycle N, pready=1 at first ACCESS -> SETUP N+1, ACCESS N+2, rsp_valid N+3; min 4 cycles per transfer with rsp_ready held high.
REQ-019 All APB and response outputs SHALL be registered; cmd_ready and rsp_valid SHALL be decoded from registered state only.
REQ-020 pslverr, prdata SHALL be ignored outside ACCESS with pready=1.

Reset
REQ-021 presetn low SHALL asynchronously force IDLE; psel, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pprot, pstrb, pwdata, rsp_rdata = 0; wait counter = 0.
REQ-022 Reset asserted mid-transfer SHALL abort it: psel drops without waiting for the next edge, and no response is issued after release.
REQ-023 First cycle after presetn release SHALL be IDLE with cmd_ready=1.

Verification
REQ-024 Write addr=0x04 data=0xDEADBEEF strb=0xF, pready=1 -> SETUP then one ACCESS with paddr=0x04, pwdata=0xDEADBEEF; rsp_valid 3 cycles after handshake, rsp_err=0, rsp_rdata=0.
REQ-025 Read addr=0x10, pready low 3 ACCESS cycles then high with prdata=0x12345678 -> 4 ACCESS cycles, pstrb=0, rsp_rdata=0x12345678, rsp_err=0.
REQ-026 Write with pslverr=1 at completion -> rsp_err=1; rsp_ready held low 5 cycles -> rsp_valid and rsp_err stable, cmd_ready=0 throughout.
REQ-027 TIMEOUT=16, pready held low -> exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_rdata=0; variant with pready=1 in 16th cycle -> normal completion, rsp_err=0.
REQ-028 presetn pulsed low during ACCESS -> psel=penable=0 immediately, rsp_valid never asserts; next command after release completes normally.
REQ-029 Back-to-back cmd_valid and rsp_ready held high, pready=1 -> one transfer per 4 cycles, protocol checker reports no APB violations.
